// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the vector add/subtract units.
package fp16_pkg;

  localparam int unsigned LANE_W = 16;

  localparam int          FP16_BIAS    = 15;
  localparam logic [4:0]  FP16_EXP_MAX = 5'd31;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_MAX     = 16'h7BFF;
  localparam logic [15:0] FP16_INF     = 16'h7C00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
  } fp16_t;

endpackage

// File: rtl/fp16_addsub_lane.sv
// Combinational single-lane FP16 add/subtract (a + b, or a - b when sub_i).
// Flush-to-zero on inputs and underflow, truncating rounding.
// Build option: define VSUB_SAT_EN to saturate overflow to max finite instead of infinity.
module fp16_addsub_lane
  import fp16_pkg::*;
(
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic              sub_i,
  output logic [LANE_W-1:0] y_o
);

  fp16_t a, b, b_eff, big, sml;
  logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic  a_big;
  logic [4:0]  ediff;
  logic [3:0]  shamt;
  logic [13:0] big_sig, sml_sig;
  logic [14:0] sum;
  logic [3:0]  lead, lshift;
  logic [9:0]  res_mant;
  logic signed [6:0] res_exp;
  logic [LANE_W-1:0] ovf_val;

  assign a     = a_i;
  assign b     = b_i;
  assign b_eff = {b.sign ^ sub_i, b.exp, b.mant};

  assign a_nan  = (a.exp == FP16_EXP_MAX) && (a.mant != '0);
  assign b_nan  = (b.exp == FP16_EXP_MAX) && (b.mant != '0);
  assign a_inf  = (a.exp == FP16_EXP_MAX) && (a.mant == '0);
  assign b_inf  = (b.exp == FP16_EXP_MAX) && (b.mant == '0);
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);

  // Order operands by magnitude so the magnitude subtraction never goes negative.
  always_comb begin
    a_big   = {a.exp, a.mant} >= {b.exp, b.mant};
    big     = a_big ? a : b_eff;
    sml     = a_big ? b_eff : a;
    ediff   = big.exp - sml.exp;
    shamt   = (ediff > 5'd15) ? 4'd15 : ediff[3:0];
    big_sig = {1'b1, big.mant, 3'b000};
    sml_sig = {1'b1, sml.mant, 3'b000} >> shamt;
    if (big.sign == sml.sign) begin
      sum = {1'b0, big_sig} + {1'b0, sml_sig};
    end else begin
      sum = {1'b0, big_sig} - {1'b0, sml_sig};
    end
  end

  // Leading-one position of the raw sum.
  always_comb begin
    lead = '0;
    for (int i = 0; i < 15; i++) begin
      if (sum[i]) begin
        lead = 4'(i);
      end
    end
  end

  // Normalise so the hidden bit sits at bit 13, then drop the 3 guard bits.
  always_comb begin
    lshift = 4'd13 - lead;
    if (sum[14]) begin
      res_mant = sum[13:4];
      res_exp  = $signed({2'b00, big.exp}) + 7'sd1;
    end else begin
      res_mant = 10'((sum << lshift) >> 3);
      res_exp  = $signed({2'b00, big.exp}) - $signed({3'b000, lshift});
    end
  end

`ifdef VSUB_SAT_EN
  assign ovf_val = {big.sign, FP16_MAX[14:0]};
`else
  assign ovf_val = {big.sign, FP16_INF[14:0]};
`endif

  // Special-case priority: NaN, infinities, zeros, then the normal datapath.
  always_comb begin
    y_o = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b_eff.sign))) begin
      y_o = FP16_QNAN;
    end else if (a_inf) begin
      y_o = {a.sign, FP16_INF[14:0]};
    end else if (b_inf) begin
      y_o = {b_eff.sign, FP16_INF[14:0]};
    end else if (a_zero && b_zero) begin
      y_o = {a.sign & b_eff.sign, 15'd0};
    end else if (a_zero) begin
      y_o = b_eff;
    end else if (b_zero) begin
      y_o = a;
    end else if (sum == '0) begin
      y_o = '0;
    end else if (res_exp < 7'sd1) begin
      y_o = {big.sign, 15'd0};
    end else if (res_exp >= $signed({2'b00, FP16_EXP_MAX})) begin
      y_o = ovf_val;
    end else begin
      y_o = {big.sign, res_exp[4:0], res_mant};
    end
  end

endmodule

// File: rtl/vsub_seq.sv
// Sequential FP16 vector subtractor: diff = op_1 - op_2, one lane per clock,
// start/busy/done handshake. Overflow behaviour follows VSUB_SAT_EN (see lane unit).
module vsub_seq
  import fp16_pkg::*;
#(
  parameter int unsigned LANES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LANE_W*LANES-1:0] op_1,
  input  logic [LANE_W*LANES-1:0] op_2,
  output logic                    busy,
  output logic                    done,
  output logic [LANE_W*LANES-1:0] diff
);

  localparam int unsigned     CntW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(LANES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LANES-1:0][LANE_W-1:0] op1_q, op1_d, op2_q, op2_d, diff_q, diff_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [LANE_W-1:0] lane_y;

  fp16_addsub_lane u_lane (
    .a_i   (op1_q[cnt_q]),
    .b_i   (op2_q[cnt_q]),
    .sub_i (1'b1),
    .y_o   (lane_y)
  );

  // Next-state: capture on accepted start, write one lane per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    diff_d  = diff_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          op1_d   = op_1;
          op2_d   = op_2;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        diff_d[cnt_q] = lane_y;
        if (cnt_q == LastLane) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // State and registered outputs; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      diff_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      diff_q  <= diff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;

endmodule
